xor_diff_counter: RTL and testbench
===================================

# xor_diff_counter

Bit-error accumulator that sits directly downstream of the 6-bit bitwise XOR stage and consumes its difference vector. Over a window of `WINDOW` valid samples it counts the set bits of each 6-bit difference word (mismatched bits between the two compared operands) and reports the total as an error count. It is a measurement stage: one start pulse arms it, one done pulse reports the result, and the result holds until the next run.

## Interface
- `WINDOW`, default 64: number of valid samples per measurement; must be ≥1.
- `CW`, default 10: width of the error counter; must be ≥3.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  arm a measurement; sampled only in IDLE.
- `diff`  in  6  difference vector from the XOR stage.
- `diff_vld`  in  1  `diff` is valid this cycle.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; result valid.
- `err_count`  out  CW  accumulated mismatched-bit count.
- `ovf`  out  1  count exceeded 2^CW−1 during the current run.

## Operation
- States:
  - IDLE: `start`=1 → RUN. On that edge, clear `err_count`, `ovf` and the sample counter.
  - RUN: each cycle with `diff_vld`=1, add popcount(`diff`) (0..6) to `err_count` and increment the sample counter. The accepted sample that makes the count equal `WINDOW` → DONE. That sample is included in the total.
  - DONE: lasts exactly one cycle, then → IDLE unconditionally.
- Input handling:
  - `diff_vld` is ignored in IDLE and DONE.
  - `start` is ignored in RUN and DONE; there is no restart mid-run.
  - Gaps in `diff_vld` during RUN stall the window. There is no timeout.
- Sample counter: width `$clog2(WINDOW+1)`, internal.
- Overflow: if `err_count` + popcount exceeds 2^CW−1, `ovf` is set and stays set until the next `start` is accepted.
- `err_count` holds its value in IDLE until the next accepted `start`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `err_count`=0, `ovf`=0.
- `reset_n` low at any time, including mid-RUN, forces the reset values immediately (asynchronous). The run is lost.
- `start` accepted at edge N:
  - `busy`=1 from cycle N+1.
  - `err_count`=0 in cycle N+1.
- A sample accepted at edge M is reflected in `err_count` in cycle M+1. Accumulation has one cycle of latency.
- Final sample accepted at edge L:
  - `done`=1 and `busy`=0 in cycle L+1.
  - `err_count` holds the final total in cycle L+1.
  - `done`=0 from cycle L+2.
- Earliest re-arm: `start` sampled at edge L+2, i.e. the first IDLE cycle.
- `WINDOW`=1: a single accepted sample goes RUN→DONE.

## Configuration
- `DIFFCNT_SAT_EN` defined: `err_count` saturates at 2^CW−1 and stays there for the rest of the run. `ovf` is set on the first overflow.
- `DIFFCNT_SAT_EN` undefined: `err_count` wraps modulo 2^CW. `ovf` is still set and sticky.

## Test plan
- Basic accumulate:
  - Stimulus: `WINDOW`=4, `CW`=10; `start`, then `diff` = 6'b000001, 6'b111111, 6'b000000, 6'b101010 on consecutive `diff_vld` cycles.
  - Response: `done` pulses one cycle after the 4th sample with `err_count`=10, `ovf`=0; `busy` falls with `done`.
- Valid gaps and ignored input:
  - Stimulus: same data with `diff_vld` low for 3 cycles between samples; also drive `diff`=6'b111111 with `diff_vld`=1 while in IDLE.
  - Response: `err_count`=10; the IDLE samples are not counted; `done` timing follows the last accepted sample.
- Overflow:
  - Stimulus: `WINDOW`=4, `CW`=4, every `diff`=6'b111111 (true total 24).
  - Response with `DIFFCNT_SAT_EN`: `err_count`=15, `ovf`=1.
  - Response without `DIFFCNT_SAT_EN`: `err_count`=8, `ovf`=1.
- Start ignored:
  - Stimulus: `start` pulsed after sample 2 (RUN) and again during the DONE cycle.
  - Response: the run completes normally with the correct total; the module returns to IDLE with `busy`=0 and no second run.
- Reset mid-run:
  - Stimulus: assert `reset_n`=0 after 2 of 4 samples.
  - Response: `busy`, `done`, `err_count` and `ovf` go to 0 immediately; no `done` pulse. A fresh `start` followed by 4 samples gives the correct total.
- Re-arm:
  - Stimulus: `WINDOW`=1; `start` in the first IDLE cycle after `done`, then `diff`=6'b000111.
  - Response: `err_count` clears to 0 the cycle after `start`; `done` follows with `err_count`=3.

Source files
------------

// File: rtl/xor_diff_counter.sv
// Bit-error accumulator: sums popcount(diff) over WINDOW valid samples per start/done run.
// Optional macro DIFFCNT_SAT_EN: err_count saturates at 2^CW-1 instead of wrapping.
module xor_diff_counter #(
  parameter int WINDOW = 64,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [5:0]    diff,
  input  logic          diff_vld,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] err_count,
  output logic          ovf
);

  localparam int SW = $clog2(WINDOW + 1);
  localparam logic [SW-1:0] LAST_IDX = SW'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [SW-1:0] sample_cnt;
  logic [2:0]    pop;
  logic [CW:0]   sum;
  logic [CW-1:0] next_count;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 6; i++) pop = pop + {2'b00, diff[i]};
  end

  // One extra bit on the adder exposes the carry that signals overflow.
  assign sum = {1'b0, err_count} + {{(CW-2){1'b0}}, pop};

`ifdef DIFFCNT_SAT_EN
  assign next_count = sum[CW] ? '1 : sum[CW-1:0];
`else
  assign next_count = sum[CW-1:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            sample_cnt <= '0;
            err_count  <= '0;
            ovf        <= 1'b0;
          end
        end
        RUN: begin
          if (diff_vld) begin
            err_count  <= next_count;
            sample_cnt <= sample_cnt + SW'(1);
            if (sum[CW]) ovf <= 1'b1;
            if (sample_cnt == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_diff_counter.sv
// Self-checking bench for xor_diff_counter: three instances (W4/CW10, W4/CW4, W1/CW10)
// share stimulus; directed vector table, hand-written corner sequences and random traffic.
module tb_xor_diff_counter;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [5:0] diff;
  logic       diff_vld;

  logic       busy_a, done_a, ovf_a;
  logic [9:0] cnt_a;
  logic       busy_b, done_b, ovf_b;
  logic [3:0] cnt_b;
  logic       busy_c, done_c, ovf_c;
  logic [9:0] cnt_c;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: true (unbounded) total per instance, wrapped or clamped only when compared.
  int win[3] = '{4, 4, 1};
  int cwv[3] = '{10, 4, 10};
  bit m_running[3];
  bit m_done[3];
  int m_samples[3];
  int m_total[3];

  xor_diff_counter #(.WINDOW(4), .CW(10)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .diff(diff), .diff_vld(diff_vld),
    .busy(busy_a), .done(done_a), .err_count(cnt_a), .ovf(ovf_a));

  xor_diff_counter #(.WINDOW(4), .CW(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .diff(diff), .diff_vld(diff_vld),
    .busy(busy_b), .done(done_b), .err_count(cnt_b), .ovf(ovf_b));

  xor_diff_counter #(.WINDOW(1), .CW(10)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start), .diff(diff), .diff_vld(diff_vld),
    .busy(busy_c), .done(done_c), .err_count(cnt_c), .ovf(ovf_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic       v;
    logic [5:0] d;
    logic       exp_busy;
    logic       exp_done;
    logic [9:0] exp_cnt;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int exp_count(input int k);
    int mx;
    mx = (1 << cwv[k]) - 1;
`ifdef DIFFCNT_SAT_EN
    return (m_total[k] > mx) ? mx : m_total[k];
`else
    return m_total[k] % (1 << cwv[k]);
`endif
  endfunction

  function automatic bit exp_ovf(input int k);
    return m_total[k] > ((1 << cwv[k]) - 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_running[k] = 0;
      m_done[k]    = 0;
      m_samples[k] = 0;
      m_total[k]   = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (m_done[k]) begin
        m_done[k] = 0;
      end else if (!m_running[k]) begin
        if (start) begin
          m_running[k] = 1;
          m_samples[k] = 0;
          m_total[k]   = 0;
        end
      end else if (diff_vld) begin
        m_total[k]   += $countones(diff);
        m_samples[k] += 1;
        if (m_samples[k] == win[k]) begin
          m_running[k] = 0;
          m_done[k]    = 1;
        end
      end
    end
  endtask

  task automatic check_inst(input int k, input logic b, input logic dn, input int c, input logic o);
    check_output($sformatf("i%0d_busy", k), int'(b), int'(m_running[k]));
    check_output($sformatf("i%0d_done", k), int'(dn), int'(m_done[k]));
    check_output($sformatf("i%0d_err_count", k), c, exp_count(k));
    check_output($sformatf("i%0d_ovf", k), int'(o), int'(exp_ovf(k)));
  endtask

  task automatic check_all();
    check_inst(0, busy_a, done_a, int'(cnt_a), ovf_a);
    check_inst(1, busy_b, done_b, int'(cnt_b), ovf_b);
    check_inst(2, busy_c, done_c, int'(cnt_c), ovf_c);
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare just after it.
  task automatic apply_stimulus(input logic s, input logic v, input logic [5:0] d);
    start    = s;
    diff_vld = v;
    diff     = d;
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    check_all();
  endtask

  // Reset is asserted between edges and checked before the next edge arrives.
  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all();
    check_output("rst_busy", int'(busy_a), 0);
    check_output("rst_done", int'(done_a), 0);
    check_output("rst_err_count", int'(cnt_a), 0);
    check_output("rst_ovf", int'(ovf_a), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic add_vec(input logic s, input logic v, input logic [5:0] d,
                         input logic b, input logic dn, input logic [9:0] c, input logic o);
    vec_t r;
    r.s = s; r.v = v; r.d = d;
    r.exp_busy = b; r.exp_done = dn; r.exp_cnt = c; r.exp_ovf = o;
    vecs.push_back(r);
  endtask

  initial begin
    int ovf_expect;

    reset_n  = 1'b0;
    start    = 1'b0;
    diff     = '0;
    diff_vld = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // Basic accumulate, then IDLE samples that must be ignored.
    add_vec(1, 0, 6'b000000, 1, 0, 0, 0);
    add_vec(0, 1, 6'b000001, 1, 0, 1, 0);
    add_vec(0, 1, 6'b111111, 1, 0, 7, 0);
    add_vec(0, 1, 6'b000000, 1, 0, 7, 0);
    add_vec(0, 1, 6'b101010, 0, 1, 10, 0);
    add_vec(0, 1, 6'b111111, 0, 0, 10, 0);
    add_vec(0, 1, 6'b111111, 0, 0, 10, 0);
    // Same data with three-cycle valid gaps.
    add_vec(1, 0, 6'b000000, 1, 0, 0, 0);
    add_vec(0, 1, 6'b000001, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 6'b111111, 1, 0, 1, 0);
    add_vec(0, 1, 6'b111111, 1, 0, 7, 0);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 6'b111111, 1, 0, 7, 0);
    add_vec(0, 1, 6'b000000, 1, 0, 7, 0);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 6'b010101, 1, 0, 7, 0);
    add_vec(0, 1, 6'b101010, 0, 1, 10, 0);
    add_vec(0, 0, 6'b000000, 0, 0, 10, 0);
    // Start in RUN and in DONE is ignored; no second run follows.
    add_vec(1, 0, 6'b000000, 1, 0, 0, 0);
    add_vec(0, 1, 6'b000001, 1, 0, 1, 0);
    add_vec(0, 1, 6'b111111, 1, 0, 7, 0);
    add_vec(1, 0, 6'b000000, 1, 0, 7, 0);
    add_vec(0, 1, 6'b000000, 1, 0, 7, 0);
    add_vec(0, 1, 6'b101010, 0, 1, 10, 0);
    add_vec(1, 0, 6'b000000, 0, 0, 10, 0);
    add_vec(0, 1, 6'b111111, 0, 0, 10, 0);
    add_vec(0, 0, 6'b000000, 0, 0, 10, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].s, vecs[i].v, vecs[i].d);
      check_output($sformatf("vec%0d_busy", i), int'(busy_a), int'(vecs[i].exp_busy));
      check_output($sformatf("vec%0d_done", i), int'(done_a), int'(vecs[i].exp_done));
      check_output($sformatf("vec%0d_err_count", i), int'(cnt_a), int'(vecs[i].exp_cnt));
      check_output($sformatf("vec%0d_ovf", i), int'(ovf_a), int'(vecs[i].exp_ovf));
    end

    // Overflow: four all-ones words, true total 24.
    apply_stimulus(1, 0, 6'b000000);
    repeat (4) apply_stimulus(0, 1, 6'b111111);
`ifdef DIFFCNT_SAT_EN
    ovf_expect = 15;
`else
    ovf_expect = 8;
`endif
    check_output("ovf_cw10_count", int'(cnt_a), 24);
    check_output("ovf_cw10_flag", int'(ovf_a), 0);
    check_output("ovf_cw4_count", int'(cnt_b), ovf_expect);
    check_output("ovf_cw4_flag", int'(ovf_b), 1);
    check_output("ovf_cw4_done", int'(done_b), 1);
    apply_stimulus(0, 0, 6'b000000);
    check_output("ovf_cw4_hold", int'(cnt_b), ovf_expect);

    // Reset in the middle of a run, then a clean run.
    apply_stimulus(1, 0, 6'b000000);
    apply_stimulus(0, 1, 6'b111111);
    apply_stimulus(0, 1, 6'b111111);
    pulse_reset();
    apply_stimulus(0, 0, 6'b000000);
    apply_stimulus(1, 0, 6'b000000);
    apply_stimulus(0, 1, 6'b000001);
    apply_stimulus(0, 1, 6'b111111);
    apply_stimulus(0, 1, 6'b000000);
    apply_stimulus(0, 1, 6'b101010);
    check_output("post_rst_count", int'(cnt_a), 10);
    check_output("post_rst_done", int'(done_a), 1);
    apply_stimulus(0, 0, 6'b000000);

    // WINDOW=1 re-arm in the first IDLE cycle after done.
    apply_stimulus(1, 0, 6'b000000);
    apply_stimulus(0, 1, 6'b000111);
    check_output("w1_done1", int'(done_c), 1);
    check_output("w1_count1", int'(cnt_c), 3);
    apply_stimulus(0, 0, 6'b000000);
    check_output("w1_idle_done", int'(done_c), 0);
    apply_stimulus(1, 0, 6'b000000);
    check_output("w1_rearm_busy", int'(busy_c), 1);
    check_output("w1_rearm_clear", int'(cnt_c), 0);
    apply_stimulus(0, 1, 6'b000111);
    check_output("w1_done2", int'(done_c), 1);
    check_output("w1_count2", int'(cnt_c), 3);
    check_output("w1_busy2", int'(busy_c), 0);

    // Random traffic against the model, with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        pulse_reset();
      end else begin
        apply_stimulus(logic'($urandom_range(0, 3) == 0),
                       logic'($urandom_range(0, 1)),
                       6'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
